// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a single-entry output
// buffer toward decode, and redirect/misaligned-target fault handling.
package cotm32_pkg;
  parameter int unsigned XLEN = 32;
endpackage

module fetch_unit
  import cotm32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  input  logic            i_ready,
  output logic            o_fault,
  output logic [XLEN-1:0] o_fault_pc
);

  typedef enum logic [1:0] {StReq, StWait, StFault} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            stale_q, stale_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic req_valid;
  logic aligned;

  assign aligned   = (i_redirect_pc[1:0] == 2'b00);
  // A request is only issued when the buffer will be free next cycle.
  assign req_valid = (state_q == StReq) && !i_redirect && (!valid_q || i_ready) && !i_rst;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    stale_d    = stale_q;
    valid_d    = valid_q;
    out_pc_d   = out_pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (i_redirect) begin
      valid_d = 1'b0;
      if (aligned) begin
        pc_d    = i_redirect_pc;
        fault_d = 1'b0;
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = i_redirect_pc;
      end
      if (state_q == StWait) begin
        if (i_imem_rsp_valid) begin
          stale_d = 1'b0;
          state_d = aligned ? StReq : StFault;
        end else begin
          stale_d = 1'b1;
        end
      end else begin
        state_d = aligned ? StReq : StFault;
      end
    end else begin
      if (valid_q && i_ready) valid_d = 1'b0;
      unique case (state_q)
        StReq: begin
          if (req_valid && i_imem_req_ready) begin
            state_d  = StWait;
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
          end
        end
        StWait: begin
          if (i_imem_rsp_valid) begin
            stale_d = 1'b0;
            if (stale_q) begin
              // Pending fault from an earlier misaligned redirect takes effect now.
              state_d = fault_q ? StFault : StReq;
            end else begin
              valid_d  = 1'b1;
              out_pc_d = req_pc_q;
              instr_d  = i_imem_rsp_data;
              state_d  = StReq;
            end
          end
        end
        StFault: ;
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      stale_q    <= 1'b0;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      stale_q    <= stale_d;
      valid_q    <= valid_d;
      out_pc_q   <= out_pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign o_imem_req_valid = req_valid;
  assign o_imem_addr      = pc_q;
  assign o_valid          = valid_q;
  assign o_pc             = out_pc_q;
  assign o_instr          = instr_q;
  assign o_fault          = fault_q;
  assign o_fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-randomizing memory and a transaction-level
// model of the fetch stream predict every output each cycle.
module tb_fetch_unit;
  import cotm32_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic            i_clk;
  logic            i_rst;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req_valid;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_req_ready;
  logic            i_imem_rsp_valid;
  logic [XLEN-1:0] i_imem_rsp_data;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;
  logic            i_ready;
  logic            o_fault;
  logic [XLEN-1:0] o_fault_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_valid          (o_valid),
    .o_pc             (o_pc),
    .o_instr          (o_instr),
    .i_ready          (i_ready),
    .o_fault          (o_fault),
    .o_fault_pc       (o_fault_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total;
  int n_bad;

  // Transaction-level view of the fetch stream.
  logic [31:0] m_pc;
  logic        m_busy;
  logic [31:0] m_req_addr;
  logic        m_drop;
  logic        m_fault;
  logic [31:0] m_fault_pc;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;

  // Memory side: at most one pending response, delivered 1..4 cycles after acceptance.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;

  logic        exp_req;
  logic        act_req;
  logic [31:0] tgt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = RST_PC;
    m_busy     = 1'b0;
    m_req_addr = '0;
    m_drop     = 1'b0;
    m_fault    = 1'b0;
    m_fault_pc = '0;
    m_valid    = 1'b0;
    m_opc      = '0;
    m_oinstr   = '0;
  endtask

  initial begin
    n_total          = 0;
    n_bad            = 0;
    mem_pend         = 1'b0;
    mem_cnt          = 0;
    mem_data         = '0;
    i_rst            = 1'b1;
    i_redirect       = 1'b0;
    i_redirect_pc    = '0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_ready          = 1'b0;
    model_reset();
    @(posedge i_clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge i_clk);
      i_rst      = (cyc < 2) || ($urandom_range(0, 199) == 0);
      i_redirect = ($urandom_range(0, 11) == 0);
      tgt        = {20'h0, 10'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
      i_redirect_pc    = i_redirect ? tgt : $urandom;
      i_ready          = ($urandom_range(0, 9) < 7);
      i_imem_req_ready = !mem_pend && ($urandom_range(0, 3) != 0);
      if (mem_pend && mem_cnt == 0) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mem_data;
      end else begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = $urandom;
      end
      #1;
      exp_req = !i_rst && !m_busy && !m_fault && !i_redirect && (!m_valid || i_ready);
      act_req = o_imem_req_valid;
      check_val("req_valid", {31'b0, o_imem_req_valid}, {31'b0, exp_req});
      if (exp_req) check_val("imem_addr", o_imem_addr, m_pc);
      check_val("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
      check_val("o_pc", o_pc, m_opc);
      check_val("o_instr", o_instr, m_oinstr);
      check_val("o_fault", {31'b0, o_fault}, {31'b0, m_fault});
      check_val("o_fault_pc", o_fault_pc, m_fault_pc);

      @(posedge i_clk);
      if (i_imem_rsp_valid) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (act_req && i_imem_req_ready) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(0, 3);
        mem_data = $urandom;
      end

      if (i_rst) begin
        model_reset();
      end else if (i_redirect) begin
        m_valid = 1'b0;
        if (m_busy) begin
          if (i_imem_rsp_valid) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
          end else begin
            m_drop = 1'b1;
          end
        end
        if (i_redirect_pc[1:0] == 2'b00) begin
          m_pc    = i_redirect_pc;
          m_fault = 1'b0;
        end else begin
          m_fault    = 1'b1;
          m_fault_pc = i_redirect_pc;
        end
      end else begin
        if (m_busy && i_imem_rsp_valid) begin
          m_busy = 1'b0;
          if (m_drop) begin
            m_drop = 1'b0;
          end else begin
            m_valid  = 1'b1;
            m_opc    = m_req_addr;
            m_oinstr = i_imem_rsp_data;
          end
        end else if (m_valid && i_ready) begin
          m_valid = 1'b0;
        end
        if (exp_req && i_imem_req_ready) begin
          m_busy     = 1'b1;
          m_req_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
